// File: rtl/dsr_pkg.sv
// Shared constants for the deserializer frame pipeline: lane/sample widths,
// default frame-lane pattern and the frame-pipe state encoding.
package dsr_pkg;
  localparam int LANE_W   = 6;
  localparam int SAMPLE_W = 2 * LANE_W;

  localparam logic [LANE_W-1:0] FRM_PAT_DEF = 6'b111000;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_DELAY = 2'd1;
  localparam logic [1:0] ST_RUN   = 2'd2;
  localparam logic [1:0] ST_LOST  = 2'd3;
endpackage

// File: rtl/dsr_word_pack.sv
// Interleaves the even/odd deserializer lanes into one sample word:
// word[2i] = din_evn[i], word[2i+1] = din_odd[i].
module dsr_word_pack
  import dsr_pkg::*;
(
  input  logic [LANE_W-1:0]   din_evn,
  input  logic [LANE_W-1:0]   din_odd,
  output logic [SAMPLE_W-1:0] word
);

  always_comb begin
    word = '0;
    for (int i = 0; i < LANE_W; i++) begin
      word[2*i]   = din_evn[i];
      word[2*i+1] = din_odd[i];
    end
  end

endmodule

// File: rtl/dsr_frame_pipe.sv
// Sample pipeline behind the deserializer alignment FSM: assembles 12-bit words,
// starts output a fixed delay after alignment, and requests realignment on lock loss.
module dsr_frame_pipe
  import dsr_pkg::*;
#(
  parameter logic [LANE_W-1:0] FRM_PAT    = FRM_PAT_DEF,
  parameter int                PIPE_DLY   = 4,
  parameter int                ERR_THRESH = 3
) (
  input  logic                CLK,
  input  logic                RST_N,
  input  logic                STRT_PIPE,
  input  logic                ALIGNED,
  input  logic [LANE_W-1:0]   FRAME,
  input  logic [LANE_W-1:0]   DIN_EVN,
  input  logic [LANE_W-1:0]   DIN_ODD,
  output logic [SAMPLE_W-1:0] DOUT,
  output logic                DOUT_VLD,
  output logic                PIPE_RUN,
  output logic                REALIGN,
  output logic [7:0]          ERR_CNT,
  output logic [1:0]          STATE_DBG
);

  // DELAY holds PIPE_DLY-1 cycles; the counter starts at 0 on entry.
  localparam logic [3:0] DLY_LAST = (PIPE_DLY > 1) ? 4'(PIPE_DLY - 2) : 4'd0;
  localparam logic [3:0] MISS_THR = 4'(ERR_THRESH);

  logic [1:0]          state_q,    state_d;
  logic [3:0]          dly_cnt_q,  dly_cnt_d;
  logic [3:0]          miss_cnt_q, miss_cnt_d;
  logic [7:0]          err_cnt_q,  err_cnt_d;
  logic [LANE_W-1:0]   frame_q,    frame_d;
  logic [SAMPLE_W-1:0] dout_q,     dout_d;
  logic [SAMPLE_W-1:0] packed_word;
  logic                frame_miss;

  dsr_word_pack u_pack (
    .din_evn (DIN_EVN),
    .din_odd (DIN_ODD),
    .word    (packed_word)
  );

  always_comb begin
    state_d    = state_q;
    dly_cnt_d  = dly_cnt_q;
    miss_cnt_d = miss_cnt_q;
    err_cnt_d  = err_cnt_q;
    frame_d    = FRAME;
    dout_d     = packed_word;
    frame_miss = (frame_q != FRM_PAT);

    case (state_q)
      ST_IDLE: begin
        if (STRT_PIPE) begin
          dly_cnt_d  = 4'd0;
          miss_cnt_d = 4'd0;
          state_d    = (PIPE_DLY <= 1) ? ST_RUN : ST_DELAY;
        end
      end
      ST_DELAY: begin
        // ALIGNED is not yet trustworthy in the first DELAY cycle.
        if (!ALIGNED && (dly_cnt_q != 4'd0)) begin
          state_d = ST_IDLE;
        end else if (dly_cnt_q == DLY_LAST) begin
          state_d    = ST_RUN;
          miss_cnt_d = 4'd0;
        end else begin
          dly_cnt_d = dly_cnt_q + 4'd1;
        end
      end
      ST_RUN: begin
        if (frame_miss) begin
          miss_cnt_d = miss_cnt_q + 4'd1;
          if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
        end else begin
          miss_cnt_d = 4'd0;
        end
        // Upstream already restarting alignment: leave quietly, no REALIGN.
        if (!ALIGNED) begin
          state_d = ST_IDLE;
        end else if (frame_miss && ((miss_cnt_q + 4'd1) == MISS_THR)) begin
          state_d = ST_LOST;
        end
      end
      ST_LOST: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= ST_IDLE;
      dly_cnt_q  <= '0;
      miss_cnt_q <= '0;
      err_cnt_q  <= '0;
      frame_q    <= '0;
      dout_q     <= '0;
    end else begin
      state_q    <= state_d;
      dly_cnt_q  <= dly_cnt_d;
      miss_cnt_q <= miss_cnt_d;
      err_cnt_q  <= err_cnt_d;
      frame_q    <= frame_d;
      dout_q     <= dout_d;
    end
  end

  // DOUT updates every cycle; DOUT_VLD marks the cycles a consumer may take it.
  assign DOUT      = dout_q;
  assign DOUT_VLD  = (state_q == ST_RUN);
  assign PIPE_RUN  = (state_q == ST_RUN);
  assign REALIGN   = (state_q == ST_LOST);
  assign ERR_CNT   = err_cnt_q;
  assign STATE_DBG = state_q;

endmodule

// File: tb/tb_dsr_frame_pipe.sv
// Bench for dsr_frame_pipe: directed scenarios plus randomized traffic, all
// checked against a cycle-level behavioural model of the frame pipeline.
module tb_dsr_frame_pipe;
  import dsr_pkg::*;

  localparam int         PIPE_DLY   = 4;
  localparam int         ERR_THRESH = 3;
  localparam logic [5:0] PAT        = 6'b111000;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        STRT_PIPE = 1'b0;
  logic        ALIGNED = 1'b0;
  logic [5:0]  FRAME = 6'd0;
  logic [5:0]  DIN_EVN = 6'd0;
  logic [5:0]  DIN_ODD = 6'd0;
  logic [11:0] DOUT;
  logic        DOUT_VLD, PIPE_RUN, REALIGN;
  logic [7:0]  ERR_CNT;
  logic [1:0]  STATE_DBG;

  int total = 0;
  int bad   = 0;

  logic [11:0] exp_q[$];

  dsr_frame_pipe #(.FRM_PAT(PAT), .PIPE_DLY(PIPE_DLY), .ERR_THRESH(ERR_THRESH)) dut (
    .CLK(CLK), .RST_N(RST_N), .STRT_PIPE(STRT_PIPE), .ALIGNED(ALIGNED),
    .FRAME(FRAME), .DIN_EVN(DIN_EVN), .DIN_ODD(DIN_ODD),
    .DOUT(DOUT), .DOUT_VLD(DOUT_VLD), .PIPE_RUN(PIPE_RUN), .REALIGN(REALIGN),
    .ERR_CNT(ERR_CNT), .STATE_DBG(STATE_DBG)
  );

  // ---------------- clock ----------------
  always #5 CLK = ~CLK;

  // ---------------- reference model ----------------
  typedef enum int {M_IDLE, M_WAIT, M_RUN, M_LOST} mphase_e;
  mphase_e     m_phase;
  int          m_age, m_streak, m_errs;
  logic [5:0]  m_prev_frame;
  logic [11:0] m_dout;

  function automatic logic [11:0] interleave(input logic [5:0] e, input logic [5:0] o);
    logic [11:0] w;
    w = '0;
    for (int i = 0; i < 6; i++)
      w = w | (12'(e[i]) << (2*i)) | (12'(o[i]) << (2*i + 1));
    return w;
  endfunction

  // {DOUT, DOUT_VLD, PIPE_RUN, REALIGN, ERR_CNT} as the model predicts them
  function automatic logic [22:0] model_outs();
    logic [7:0] e;
    e = (m_errs > 255) ? 8'd255 : 8'(m_errs);
    return {m_dout, m_phase == M_RUN, m_phase == M_RUN, m_phase == M_LOST, e};
  endfunction

  task automatic model_reset();
    m_phase = M_IDLE; m_age = 0; m_streak = 0; m_errs = 0;
    m_prev_frame = '0; m_dout = '0;
  endtask

  task automatic model_step();
    if (!RST_N) begin
      model_reset();
      return;
    end
    case (m_phase)
      M_IDLE: if (STRT_PIPE) begin
        m_age = 1; m_streak = 0;
        m_phase = (PIPE_DLY == 1) ? M_RUN : M_WAIT;
      end
      M_WAIT: begin
        if (!ALIGNED && m_age > 1) m_phase = M_IDLE;
        else if (m_age >= PIPE_DLY - 1) begin m_phase = M_RUN; m_streak = 0; end
        else m_age++;
      end
      M_RUN: begin
        if (m_prev_frame != PAT) begin m_errs++; m_streak++; end
        else m_streak = 0;
        if (!ALIGNED) m_phase = M_IDLE;
        else if (m_streak >= ERR_THRESH) m_phase = M_LOST;
      end
      M_LOST: m_phase = M_IDLE;
      default: m_phase = M_IDLE;
    endcase
    m_prev_frame = FRAME;
    m_dout = interleave(DIN_EVN, DIN_ODD);
  endtask

  // ---------------- driver ----------------
  task automatic tick();
    @(posedge CLK);
    model_step();
    #2;
  endtask

  task automatic start_run();
    ALIGNED = 1'b1; FRAME = PAT; STRT_PIPE = 1'b1;
    tick();
    STRT_PIPE = 1'b0;
    repeat (PIPE_DLY) tick();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    RST_N = 1'b0;
    DIN_EVN = 6'h2A; DIN_ODD = 6'h15; STRT_PIPE = 1'b1; ALIGNED = 1'b1;
    repeat (2) tick();
    total++;
    if ({DOUT, DOUT_VLD, PIPE_RUN, REALIGN, ERR_CNT} !== 23'd0) begin
      bad++;
      $display("FAIL reset_outputs got=%h exp=0", {DOUT, DOUT_VLD, PIPE_RUN, REALIGN, ERR_CNT});
    end
    STRT_PIPE = 1'b0; ALIGNED = 1'b0;
    RST_N = 1'b1;
    tick();
  endtask

  task automatic test_start_latency();
    int first;
    first = -1;
    ALIGNED = 1'b1; FRAME = PAT; STRT_PIPE = 1'b1;
    tick();
    STRT_PIPE = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      total++;
      if (DOUT_VLD !== (m_phase == M_RUN)) begin
        bad++;
        $display("FAIL start_vld cycle=%0d got=%b exp=%b", c, DOUT_VLD, m_phase == M_RUN);
      end
      if (DOUT_VLD === 1'b1 && first < 0) first = c;
      tick();
    end
    total++;
    if (first != PIPE_DLY) begin
      bad++;
      $display("FAIL start_latency got=%0d exp=%0d", first, PIPE_DLY);
    end
  endtask

  task automatic test_pack();
    logic [11:0] e;
    DIN_EVN = 6'h3F; DIN_ODD = 6'h00;
    tick();
    total++;
    if (DOUT !== 12'h555) begin bad++; $display("FAIL pack_evn got=%h exp=555", DOUT); end
    DIN_EVN = 6'h00; DIN_ODD = 6'h3F;
    tick();
    total++;
    if (DOUT !== 12'hAAA) begin bad++; $display("FAIL pack_odd got=%h exp=aaa", DOUT); end
    for (int i = 0; i < 16; i++) begin
      DIN_EVN = 6'($urandom); DIN_ODD = 6'($urandom);
      exp_q.push_back(interleave(DIN_EVN, DIN_ODD));
      tick();
      e = exp_q.pop_front();
      total++;
      if (DOUT !== e || DOUT_VLD !== 1'b1) begin
        bad++;
        $display("FAIL pack_rand i=%0d got=%h/%b exp=%h/1", i, DOUT, DOUT_VLD, e);
      end
    end
  endtask

  task automatic test_frame_errors();
    int pulses;
    FRAME = 6'b000111; tick(); tick();
    FRAME = PAT;
    repeat (4) tick();
    total++;
    if (ERR_CNT !== 8'd2 || PIPE_RUN !== 1'b1) begin
      bad++;
      $display("FAIL two_bad got=err%0d run%b exp=err2 run1", ERR_CNT, PIPE_RUN);
    end
    pulses = 0;
    FRAME = 6'b101010;
    for (int c = 0; c < 8; c++) begin
      // a start pulse while leaving LOST must be ignored
      STRT_PIPE = (m_phase == M_LOST);
      tick();
      if (c == 2) FRAME = PAT;
      total++;
      if ({DOUT_VLD, PIPE_RUN, REALIGN, ERR_CNT} !== model_outs()[10:0]) begin
        bad++;
        $display("FAIL lock_loss c=%0d got=%h exp=%h", c,
                 {DOUT_VLD, PIPE_RUN, REALIGN, ERR_CNT}, model_outs()[10:0]);
      end
      if (REALIGN === 1'b1) begin
        pulses++;
        total++;
        if (DOUT_VLD !== 1'b0) begin bad++; $display("FAIL vld_in_lost got=%b exp=0", DOUT_VLD); end
      end
    end
    STRT_PIPE = 1'b0;
    total++;
    if (pulses != 1 || ERR_CNT !== 8'd5 || PIPE_RUN !== 1'b0) begin
      bad++;
      $display("FAIL realign_pulse got=p%0d err%0d run%b exp=p1 err5 run0", pulses, ERR_CNT, PIPE_RUN);
    end
  endtask

  task automatic test_delay_abort();
    int seen;
    // ALIGNED low only in the first DELAY cycle does not abort
    ALIGNED = 1'b1; STRT_PIPE = 1'b1; tick();
    STRT_PIPE = 1'b0; ALIGNED = 1'b0; tick();
    ALIGNED = 1'b1; tick(); tick();
    total++;
    if (DOUT_VLD !== 1'b1 || m_phase != M_RUN) begin
      bad++;
      $display("FAIL early_aligned_low got=%b exp=1", DOUT_VLD);
    end
    ALIGNED = 1'b0; tick();
    total++;
    if (PIPE_RUN !== 1'b0 || REALIGN !== 1'b0) begin
      bad++;
      $display("FAIL aligned_drop_run got=run%b re%b exp=run0 re0", PIPE_RUN, REALIGN);
    end
    ALIGNED = 1'b1; STRT_PIPE = 1'b1; tick();
    STRT_PIPE = 1'b0; tick();
    ALIGNED = 1'b0;
    seen = 0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (DOUT_VLD === 1'b1 || REALIGN === 1'b1) seen++;
    end
    total++;
    if (seen != 0 || STATE_DBG !== ST_IDLE) begin
      bad++;
      $display("FAIL delay_abort got=seen%0d st%0d exp=seen0 st%0d", seen, STATE_DBG, ST_IDLE);
    end
    ALIGNED = 1'b1;
  endtask

  task automatic test_saturate();
    start_run();
    for (int i = 0; i < 135; i++) begin
      FRAME = 6'b000000; tick(); tick();
      FRAME = PAT; tick();
    end
    repeat (3) tick();
    total++;
    if (ERR_CNT !== 8'd255 || ERR_CNT !== model_outs()[7:0] || PIPE_RUN !== 1'b1) begin
      bad++;
      $display("FAIL err_saturate got=err%0d run%b exp=err255 run1", ERR_CNT, PIPE_RUN);
    end
  endtask

  task automatic test_strt_in_run_and_reset();
    STRT_PIPE = 1'b1; tick();
    STRT_PIPE = 1'b0;
    for (int c = 0; c < 6; c++) begin
      total++;
      if (PIPE_RUN !== 1'b1 || DOUT_VLD !== 1'b1) begin
        bad++;
        $display("FAIL strt_in_run c=%0d got=%b%b exp=11", c, PIPE_RUN, DOUT_VLD);
      end
      tick();
    end
    DIN_EVN = 6'h3F; DIN_ODD = 6'h3F; tick();
    #1 RST_N = 1'b0;
    model_reset();
    #1;
    total++;
    if ({DOUT, DOUT_VLD, PIPE_RUN, REALIGN, ERR_CNT} !== 23'd0) begin
      bad++;
      $display("FAIL async_reset got=%h exp=0", {DOUT, DOUT_VLD, PIPE_RUN, REALIGN, ERR_CNT});
    end
    tick();
    RST_N = 1'b1;
    tick();
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      STRT_PIPE = ($urandom_range(0, 9) == 0);
      ALIGNED   = ($urandom_range(0, 19) != 0);
      FRAME     = ($urandom_range(0, 3) == 0) ? 6'($urandom) : PAT;
      DIN_EVN   = 6'($urandom);
      DIN_ODD   = 6'($urandom);
      tick();
      total++;
      if ({DOUT, DOUT_VLD, PIPE_RUN, REALIGN, ERR_CNT} !== model_outs()) begin
        bad++;
        $display("FAIL random c=%0d got=%h exp=%h", c,
                 {DOUT, DOUT_VLD, PIPE_RUN, REALIGN, ERR_CNT}, model_outs());
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    model_reset();
    test_reset();
    test_start_latency();
    test_pack();
    test_frame_errors();
    test_delay_abort();
    test_saturate();
    test_strt_in_run_and_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
